// File: rtl/multi_blink_pkg.sv
// Shared definitions for multi_blink: channel mode encoding and PWM geometry.
// The optional PWM dimming feature is enabled with MULTI_BLINK_PWM_EN.
package multi_blink_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  localparam int PWM_STEPS = 16;
  localparam int PWM_W     = $clog2(PWM_STEPS);

endpackage

// File: rtl/blink_channel.sv
// One LED channel: OFF/ON/BLINK/BURST state machine advanced by the shared tick.
// MULTI_BLINK_PWM_EN adds a per-channel 16-step duty gate on the lit state.
module blink_channel
  import multi_blink_pkg::*;
#(
  parameter int PER_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_mode,
  input  logic [PER_W-1:0] cfg_half,
  input  logic [CNT_W-1:0] cfg_count,
`ifdef MULTI_BLINK_PWM_EN
  input  logic [PWM_W-1:0] cfg_duty,
`endif
  input  logic             tick,
  output logic             led,
  output logic             busy,
  output logic             done
);

  mode_e            mode_q, mode_d;
  logic [PER_W-1:0] half_q, half_d;
  logic [PER_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lit_q, lit_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    mode_d  = mode_q;
    half_d  = half_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    lit_d   = lit_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (cfg_we) begin
      // A transfer restarts the channel and masks any coincident tick.
      phase_d = '0;
      mode_d  = mode_e'(cfg_mode);
      half_d  = (cfg_half == '0) ? PER_W'(1) : cfg_half;
      cnt_d   = cfg_count;
      case (mode_e'(cfg_mode))
        MODE_OFF: begin
          lit_d  = 1'b0;
          busy_d = 1'b0;
        end
        MODE_ON: begin
          lit_d  = 1'b1;
          busy_d = 1'b0;
        end
        MODE_BLINK: begin
          lit_d  = 1'b1;
          busy_d = 1'b1;
        end
        default: begin
          if (cfg_count == '0) begin
            mode_d = MODE_OFF;
            lit_d  = 1'b0;
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            lit_d  = 1'b1;
            busy_d = 1'b1;
          end
        end
      endcase
    end else if (tick && (mode_q == MODE_BLINK || mode_q == MODE_BURST)) begin
      if (phase_q == half_q - PER_W'(1)) begin
        phase_d = '0;
        lit_d   = !lit_q;
        // Bursts count falling edges; the last one retires the channel.
        if (mode_q == MODE_BURST && lit_q) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            mode_d = MODE_OFF;
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end
      end else begin
        phase_d = phase_q + PER_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_OFF;
      half_q  <= '0;
      phase_q <= '0;
      cnt_q   <= '0;
      lit_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      half_q  <= half_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      lit_q   <= lit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef MULTI_BLINK_PWM_EN
  logic [PWM_W-1:0] pwm_q, pwm_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic             led_q, led_d;

  always_comb begin
    pwm_d  = pwm_q + PWM_W'(1);
    duty_d = cfg_we ? cfg_duty : duty_q;
    led_d  = lit_d && (pwm_q < duty_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q  <= '0;
      duty_q <= '0;
      led_q  <= 1'b0;
    end else begin
      pwm_q  <= pwm_d;
      duty_q <= duty_d;
      led_q  <= led_d;
    end
  end

  assign led = led_q;
`else
  assign led = lit_q;
`endif

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/multi_blink.sv
// Multi-channel LED blinker: free-running tick prescaler plus NUM_CH blink_channel
// instances. MULTI_BLINK_PWM_EN adds the cfg_duty port and PWM dimming.
module multi_blink
  import multi_blink_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1000,
  parameter int PER_W   = 16,
  parameter int CNT_W   = 8
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         cfg_valid,
  output logic                                         cfg_ready,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [1:0]                                   cfg_mode,
  input  logic [PER_W-1:0]                             cfg_half,
  input  logic [CNT_W-1:0]                             cfg_count,
`ifdef MULTI_BLINK_PWM_EN
  input  logic [PWM_W-1:0]                             cfg_duty,
`endif
  output logic [NUM_CH-1:0]                            led,
  output logic [NUM_CH-1:0]                            busy,
  output logic [NUM_CH-1:0]                            done
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  // Assert asynchronously, release on a common edge for prescaler and channels.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_int_n = rst_sync_q[1];

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;

  always_comb begin
    tick  = (pre_q == PRE_W'(DIV - 1));
    pre_d = tick ? '0 : pre_q + PRE_W'(1);
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) pre_q <= '0;
    else            pre_q <= pre_d;
  end

  assign cfg_ready = rst_n;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic we;
    // Out-of-range channel numbers match no instance and are silently dropped.
    assign we = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

    blink_channel #(
      .PER_W (PER_W),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_int_n),
      .cfg_we    (we),
      .cfg_mode  (cfg_mode),
      .cfg_half  (cfg_half),
      .cfg_count (cfg_count),
`ifdef MULTI_BLINK_PWM_EN
      .cfg_duty  (cfg_duty),
`endif
      .tick      (tick),
      .led       (led[g]),
      .busy      (busy[g]),
      .done      (done[g])
    );
  end

endmodule

// File: tb/tb_multi_blink.sv
// Directed bench for multi_blink (DIV=10, NUM_CH=4) with an expected-value queue;
// a second NUM_CH=3 instance exercises an out-of-range channel number.
module tb_multi_blink;

  logic       clk;
  logic       rst_n;
  logic       cfg_valid, cfg_valid3;
  logic       cfg_ready, cfg_ready3;
  logic [1:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic [15:0] cfg_half;
  logic [7:0] cfg_count;
  logic [3:0] led, busy, done;
  logic [2:0] led3, busy3, done3;

  multi_blink #(.NUM_CH(4), .CLK_HZ(1000), .TICK_HZ(100), .PER_W(16), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_half(cfg_half), .cfg_count(cfg_count),
    .led(led), .busy(busy), .done(done));

  multi_blink #(.NUM_CH(3), .CLK_HZ(1000), .TICK_HZ(100), .PER_W(16), .CNT_W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_half(cfg_half), .cfg_count(cfg_count),
    .led(led3), .busy(busy3), .done(done3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic push(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sbq.push_back(x);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t x;
    n_cmp++;
    if (sbq.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty observed=%0h expected=<none>", obs);
    end else begin
      x = sbq.pop_front();
      assert (obs === x.exp) else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", x.tag, obs, x.exp);
      end
    end
  endtask

  // Called at a negedge; the transfer is taken on the following posedge.
  task automatic xfer(input int ch, input int mode, input int half, input int cnt);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_mode  = 2'(mode);
    cfg_half  = 16'(half);
    cfg_count = 8'(cnt);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  initial begin
    int n, falls, dones, aligned, drops;
    logic prev;

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_valid3 = 1'b0;
    cfg_ch = '0; cfg_mode = '0; cfg_half = '0; cfg_count = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);

    push("reset_led", 0);   chk(32'(led));
    push("reset_busy", 0);  chk(32'(busy));
    push("reset_done", 0);  chk(32'(done));
    push("cfg_ready", 1);   chk(32'(cfg_ready));

    // BURST with zero count: done only, one cycle after acceptance.
    push("b0_done", 1); push("b0_led", 0); push("b0_busy", 0);
    xfer(0, 3, 2, 0);
    chk(32'(done[0])); chk(32'(led[0])); chk(32'(busy[0]));
    push("b0_done_clr", 0);
    @(negedge clk);
    chk(32'(done[0]));

    // BLINK ch1 half=3: first phase 20..30 cycles, then exactly 30.
    push("blink_rise", 1); push("blink_busy", 1);
    xfer(1, 2, 3, 0);
    chk(32'(led[1])); chk(32'(busy[1]));
    n = 0;
    while (led[1] && n < 40) begin @(negedge clk); n++; end
    push("blink_first_phase_in_20_30", 1);
    chk(32'(n >= 20 && n <= 30));
    n = 0;
    while (!led[1] && n < 40) begin @(negedge clk); n++; end
    push("blink_low_phase", 30); chk(32'(n));
    n = 0;
    while (led[1] && n < 40) begin @(negedge clk); n++; end
    push("blink_high_phase", 30); chk(32'(n));

    // BURST ch2 half=2 count=3.
    push("burst_led_start", 1); push("burst_busy_start", 1);
    xfer(2, 3, 2, 3);
    chk(32'(led[2])); chk(32'(busy[2]));
    falls = 0; dones = 0; aligned = 0; prev = led[2];
    repeat (150) begin
      @(negedge clk);
      if (prev && !led[2]) falls++;
      if (done[2]) begin
        dones++;
        if (prev && !led[2] && falls == 3) aligned++;
      end
      prev = led[2];
    end
    push("burst_pulses", 3);      chk(32'(falls));
    push("burst_done_count", 1);  chk(32'(dones));
    push("burst_done_aligned", 1); chk(32'(aligned));
    push("burst_busy_end", 0);    chk(32'(busy[2]));
    push("burst_led_end", 0);     chk(32'(led[2]));

    // BURST ch3 count=5 aborted by ON.
    xfer(3, 3, 2, 5);
    repeat (30) @(negedge clk);
    push("abort_busy_mid", 1); chk(32'(busy[3]));
    push("abort_led", 1); push("abort_busy", 0);
    xfer(3, 1, 2, 0);
    chk(32'(led[3])); chk(32'(busy[3]));
    drops = 0; dones = 0;
    repeat (100) begin
      @(negedge clk);
      if (!led[3]) drops++;
      if (done[3]) dones++;
    end
    push("abort_led_drops", 0); chk(32'(drops));
    push("abort_no_done", 0);   chk(32'(dones));

    // Out-of-range channel on the 3-channel instance.
    cfg_valid3 = 1'b1; cfg_ch = 2'd0; cfg_mode = 2'd1; cfg_half = 16'd1; cfg_count = 8'd0;
    @(negedge clk);
    cfg_ch = 2'd3; cfg_mode = 2'd2;
    @(negedge clk);
    cfg_valid3 = 1'b0;
    repeat (5) @(negedge clk);
    push("oor_led", 3'b001); chk(32'(led3));
    push("oor_busy", 0);     chk(32'(busy3));
    push("oor_done", 0);     chk(32'(done3));

    // All channels BLINK, then asynchronous reset between clock edges.
    cfg_valid = 1'b1; cfg_mode = 2'd2; cfg_half = 16'd5; cfg_count = 8'd0;
    for (int c = 0; c < 4; c++) begin
      cfg_ch = 2'(c);
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    push("all_blink_led", 4'hf);  chk(32'(led));
    push("all_blink_busy", 4'hf); chk(32'(busy));
    #2 rst_n = 1'b0;
    #1;
    push("async_rst_led", 0);  chk(32'(led));
    push("async_rst_busy", 0); chk(32'(busy));
    push("async_rst_done", 0); chk(32'(done));
    push("async_rst_led3", 0); chk(32'(led3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
